// File: rtl/poly_voice_engine.sv
// Polyphonic voice engine: key edge detect, voice allocation, dividers, shaping, mixer.
// Optional define VOICE_STEAL_EN: a press with no free voice steals the oldest voice.
module poly_voice_engine #(
   parameter int NUM_KEYS   = 13,
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 8,
   parameter int SAMPLE_DIV = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_KEYS-1:0]   keys,
   input  logic [1:0]            oct_sel,
   input  logic [1:0]            wave_sel,
   output logic [SAMPLE_W-1:0]   sample,
   output logic                  sample_valid,
   output logic [NUM_VOICES-1:0] voice_active,
   output logic                  alloc_drop
);

   localparam int KW    = 4;
   localparam int VSH   = $clog2(NUM_VOICES);
   localparam int VW    = (VSH > 0) ? VSH : 1;
   localparam int AGE_W = 8;
   localparam int DIV_W = 10;
   localparam int CNT_W = $clog2(SAMPLE_DIV);
   localparam int SUM_W = SAMPLE_W + 4;

   logic [NUM_KEYS-1:0]   keys_q, keys_prev_q;
   logic [NUM_KEYS-1:0]   pend_q, pend_d;
   logic [NUM_VOICES-1:0] act_q, act_d;
   logic [KW-1:0]         owner_q [NUM_VOICES];
   logic [KW-1:0]         owner_d [NUM_VOICES];
   logic [AGE_W-1:0]      age_q   [NUM_VOICES];
   logic [AGE_W-1:0]      age_d   [NUM_VOICES];
   logic [SAMPLE_W-1:0]   phase_q [NUM_VOICES];
   logic [SAMPLE_W-1:0]   phase_d [NUM_VOICES];
   logic [DIV_W-1:0]      div_q   [NUM_VOICES];
   logic [DIV_W-1:0]      div_d   [NUM_VOICES];
   logic [DIV_W-1:0]      per_q   [NUM_VOICES];
   logic [DIV_W-1:0]      per_d   [NUM_VOICES];
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SAMPLE_W-1:0]   sample_q, sample_d;
   logic                  valid_q, valid_d;
   logic                  drop_q, drop_d;

   logic [NUM_KEYS-1:0]   press, rel, eff;
   logic                  svc_found, owned, free_found, do_alloc;
   logic [KW-1:0]         svc_key;
   logic [VW-1:0]         free_idx, tgt;
   logic [SUM_W-1:0]      sum;
   logic [SAMPLE_W-1:0]   mix;
`ifdef VOICE_STEAL_EN
   logic [VW-1:0]         old_idx;
   logic [AGE_W-1:0]      old_age;
`endif

   function automatic logic [6:0] key_tab(input logic [KW-1:0] k);
      logic [6:0] r;
      case (k)
         4'd0:    r = 7'd75;
         4'd1:    r = 7'd70;
         4'd2:    r = 7'd67;
         4'd3:    r = 7'd63;
         4'd4:    r = 7'd59;
         4'd5:    r = 7'd56;
         4'd6:    r = 7'd53;
         4'd7:    r = 7'd50;
         4'd8:    r = 7'd47;
         4'd9:    r = 7'd44;
         4'd10:   r = 7'd42;
         4'd11:   r = 7'd40;
         4'd12:   r = 7'd37;
         default: r = 7'd75;
      endcase
      return r;
   endfunction

   function automatic logic [DIV_W-1:0] period(input logic [KW-1:0] k,
                                                input logic [1:0]    o);
      return DIV_W'(key_tab(k)) << o;
   endfunction

   function automatic logic [SAMPLE_W-1:0] shape(input logic [SAMPLE_W-1:0] p,
                                                 input logic [1:0]          w);
      logic [SAMPLE_W-1:0] dbl;
      logic [SAMPLE_W-1:0] r;
      dbl = p << 1;
      case (w)
         2'd0:    r = p;
         2'd1:    r = {SAMPLE_W{p[SAMPLE_W-1]}};
         2'd2:    r = p[SAMPLE_W-1] ? ~dbl : dbl;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Service selection: lowest pending key, lowest free voice.
   always_comb begin
      press = keys_q & ~keys_prev_q;
      rel   = ~keys_q & keys_prev_q;
      eff   = (pend_q | press) & ~rel;
      svc_found = 1'b0;
      svc_key   = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (eff[k]) begin
            svc_found = 1'b1;
            svc_key   = KW'(k);
         end
      end
      free_found = 1'b0;
      free_idx   = '0;
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!act_q[v]) begin
            free_found = 1'b1;
            free_idx   = VW'(v);
         end
      end
      owned = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (act_q[v] && owner_q[v] == svc_key) owned = 1'b1;
      end
   end

`ifdef VOICE_STEAL_EN
   always_comb begin
      old_idx = '0;
      old_age = age_q[0];
      for (int v = 1; v < NUM_VOICES; v++) begin
         if (age_q[v] > old_age) begin
            old_idx = VW'(v);
            old_age = age_q[v];
         end
      end
   end
`endif

   always_comb begin
      act_d   = act_q;
      owner_d = owner_q;
      age_d   = age_q;
      phase_d = phase_q;
      div_d   = div_q;
      per_d   = per_q;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (act_q[v]) begin
            if (age_q[v] != '1) age_d[v] = age_q[v] + AGE_W'(1);
            // Octave change is picked up only when the divider wraps.
            if (div_q[v] == per_q[v] - DIV_W'(1)) begin
               div_d[v]   = '0;
               phase_d[v] = phase_q[v] + SAMPLE_W'(1);
               per_d[v]   = period(owner_q[v], oct_sel);
            end else begin
               div_d[v] = div_q[v] + DIV_W'(1);
            end
            if (rel[owner_q[v]]) begin
               act_d[v]   = 1'b0;
               phase_d[v] = '0;
               div_d[v]   = '0;
               age_d[v]   = '0;
            end
         end
      end
      pend_d   = eff;
      drop_d   = 1'b0;
      do_alloc = 1'b0;
      tgt      = '0;
      if (svc_found) begin
         pend_d[svc_key] = 1'b0;
         if (!owned) begin
            if (free_found) begin
               do_alloc = 1'b1;
               tgt      = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
               do_alloc = 1'b1;
               tgt      = old_idx;
`else
               drop_d   = 1'b1;
`endif
            end
         end
      end
      if (do_alloc) begin
         act_d[tgt]   = 1'b1;
         owner_d[tgt] = svc_key;
         age_d[tgt]   = '0;
         phase_d[tgt] = '0;
         div_d[tgt]   = '0;
         per_d[tgt]   = period(svc_key, oct_sel);
      end
   end

   // Mixer: average of shaped active voices.
   always_comb begin
      sum = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (act_q[v]) sum = sum + SUM_W'(shape(phase_q[v], wave_sel));
      end
      mix = SAMPLE_W'(sum >> VSH);
      if (cnt_q == CNT_W'(SAMPLE_DIV - 1)) begin
         cnt_d    = '0;
         sample_d = mix;
         valid_d  = 1'b1;
      end else begin
         cnt_d    = cnt_q + CNT_W'(1);
         sample_d = sample_q;
         valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         keys_q      <= '0;
         keys_prev_q <= '0;
         pend_q      <= '0;
         act_q       <= '0;
         owner_q     <= '{default: '0};
         age_q       <= '{default: '0};
         phase_q     <= '{default: '0};
         div_q       <= '{default: '0};
         per_q       <= '{default: '0};
         cnt_q       <= '0;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         keys_q      <= keys;
         keys_prev_q <= keys_q;
         pend_q      <= pend_d;
         act_q       <= act_d;
         owner_q     <= owner_d;
         age_q       <= age_d;
         phase_q     <= phase_d;
         div_q       <= div_d;
         per_q       <= per_d;
         cnt_q       <= cnt_d;
         sample_q    <= sample_d;
         valid_q     <= valid_d;
         drop_q      <= drop_d;
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign voice_active = act_q;
   assign alloc_drop   = drop_q;

endmodule

// File: tb/tb_poly_voice_engine.sv
// Directed bench for poly_voice_engine: allocation vectors plus timed sample sequences.
module tb_poly_voice_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [12:0] keys = '0;
   logic [1:0]  oct_sel = '0;
   logic [1:0]  wave_sel = '0;
   logic [7:0]  sample;
   logic        sample_valid;
   logic [3:0]  voice_active;
   logic        alloc_drop;

   int now;
   int n_pass;
   int n_tot;

`ifdef VOICE_STEAL_EN
   localparam bit STEAL = 1'b1;
`else
   localparam bit STEAL = 1'b0;
`endif

   poly_voice_engine dut (
      .clk          (clk),
      .reset        (reset),
      .keys         (keys),
      .oct_sel      (oct_sel),
      .wave_sel     (wave_sel),
      .sample       (sample),
      .sample_valid (sample_valid),
      .voice_active (voice_active),
      .alloc_drop   (alloc_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      logic [12:0] k;
      int          n;
      logic [3:0]  va;
      bit          drop;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         now++;
      end
      #1;
   endtask

   task automatic step_to(input int t);
      step(t - now);
   endtask

   task automatic do_reset(input logic [12:0] k);
      @(negedge clk);
      reset = 1'b1;
      keys  = '0;
      @(negedge clk);
      @(negedge clk);
      keys  = k;
      reset = 1'b0;
      now   = 0;
   endtask

   task automatic chk_sample(input string nm, input int exp);
      chk({nm, " valid"}, int'(sample_valid), 1);
      chk({nm, " sample"}, int'(sample), exp);
   endtask

   initial begin
      n_pass = 0;
      n_tot  = 0;
      now    = 0;

      tbl[0]  = '{1'b1, 13'h007, 1, 4'b0000, 1'b0};
      tbl[1]  = '{1'b0, 13'h007, 1, 4'b0001, 1'b0};
      tbl[2]  = '{1'b0, 13'h007, 1, 4'b0011, 1'b0};
      tbl[3]  = '{1'b0, 13'h007, 1, 4'b0111, 1'b0};
      tbl[4]  = '{1'b0, 13'h005, 1, 4'b0111, 1'b0};
      tbl[5]  = '{1'b0, 13'h005, 1, 4'b0101, 1'b0};
      tbl[6]  = '{1'b1, 13'h00F, 1, 4'b0000, 1'b0};
      tbl[7]  = '{1'b0, 13'h00F, 4, 4'b1111, 1'b0};
      tbl[8]  = '{1'b0, 13'h01F, 1, 4'b1111, 1'b0};
      tbl[9]  = '{1'b0, 13'h01F, 1, 4'b1111, !STEAL};
      tbl[10] = '{1'b0, 13'h01F, 1, 4'b1111, 1'b0};
      tbl[11] = '{1'b0, 13'h01E, 2, STEAL ? 4'b1111 : 4'b1110, 1'b0};
      tbl[12] = '{1'b0, 13'h00E, 2, 4'b1110, 1'b0};
      tbl[13] = '{1'b1, 13'h003, 1, 4'b0000, 1'b0};
      tbl[14] = '{1'b0, 13'h001, 1, 4'b0001, 1'b0};
      tbl[15] = '{1'b0, 13'h001, 1, 4'b0001, 1'b0};
      tbl[16] = '{1'b0, 13'h001, 2, 4'b0001, 1'b0};
      tbl[17] = '{1'b0, 13'h003, 2, 4'b0011, 1'b0};

      #12;
      chk("rst va", int'(voice_active), 0);
      chk("rst sample", int'(sample), 0);
      chk("rst valid", int'(sample_valid), 0);
      chk("rst drop", int'(alloc_drop), 0);

      for (int i = 0; i < 18; i++) begin
         if (tbl[i].rst) do_reset(tbl[i].k);
         else keys = tbl[i].k;
         step(tbl[i].n);
         chk($sformatf("vec%0d va", i), int'(voice_active), int'(tbl[i].va));
         chk($sformatf("vec%0d drop", i), int'(alloc_drop), int'(tbl[i].drop));
      end

      // Single saw voice: sample = phase >> 2, phase steps every 75 cycles.
      wave_sel = 2'd0;
      oct_sel  = 2'd0;
      do_reset(13'h001);
      step(1);
      chk("k0 +1 va", int'(voice_active), 0);
      step(1);
      chk("k0 +2 va", int'(voice_active), 1);
      step_to(256);
      chk_sample("s256", 0);
      step(1);
      chk("s257 valid", int'(sample_valid), 0);
      step_to(512);
      chk_sample("s512", 1);
      step_to(768);
      chk_sample("s768", 2);
      step_to(1024);
      chk_sample("s1024", 3);
      step_to(1280);
      chk_sample("s1280", 4);
      wave_sel = 2'd2;
      step_to(1536);
      chk_sample("tri1536", 10);
      wave_sel = 2'd3;
      step_to(1792);
      chk_sample("sil1792", 0);

      // Async reset mid-note, then reallocation of held keys.
      wave_sel = 2'd0;
      do_reset(13'h007);
      step(4);
      chk("pre-rst va", int'(voice_active), 7);
      #2;
      reset = 1'b1;
      #1;
      chk("async va", int'(voice_active), 0);
      chk("async sample", int'(sample), 0);
      chk("async valid", int'(sample_valid), 0);
      chk("async drop", int'(alloc_drop), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      now   = 0;
      step(1);
      chk("rel +1 va", int'(voice_active), 0);
      step(1);
      chk("rel +2 va", int'(voice_active), 1);
      step(2);
      chk("rel +4 va", int'(voice_active), 7);

      // Key 12, octave 3: period 296; square toggles to 255 >> 2.
      oct_sel  = 2'd3;
      wave_sel = 2'd1;
      do_reset(13'h1000);
      step_to(37888);
      chk_sample("sq37888", 0);
      step_to(38144);
      chk_sample("sq38144", 63);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/poly_voice_engine.md
POLY_VOICE_ENGINE -- requirements
Module: poly_voice_engine

Interface
REQ-001 Parameter NUM_KEYS, default 13, number of key inputs; legal 1..13.
REQ-002 Parameter NUM_VOICES, default 4, number of simultaneous voices; power of two, 1..8.
REQ-003 Parameter SAMPLE_W, default 8, width of phase counters and output sample.
REQ-004 Parameter SAMPLE_DIV, default 256, clk cycles per output sample; legal 2..4096.
REQ-005 clk  input  1  system clock; sole clock; all state is updated on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 keys  input  NUM_KEYS  level per key; 1 means the key is held; synchronous to clk.
REQ-008 oct_sel  input  2  octave-down shift amount, 0..3.
REQ-009 wave_sel  input  2  waveform select: 0 saw, 1 square, 2 triangle, 3 silent.
REQ-010 sample  output  SAMPLE_W  mixed audio sample; registered.
REQ-011 sample_valid  output  1  one-cycle pulse when sample updates.
REQ-012 voice_active  output  NUM_VOICES  bit v is high while voice v is allocated.
REQ-013 alloc_drop  output  1  one-cycle pulse when a key press is not given a voice.

Function
REQ-014 The keys input shall be registered once; press and release events are the rising and falling edges of the registered value against its previous value.
REQ-015 Each key press shall set a pending bit for that key; one pending key shall be serviced per cycle, lowest key index first.
REQ-016 A serviced press shall take the lowest-index free voice; voice_active[v] shall rise 2 cycles after keys rises, provided no other key is pending.
REQ-017 A press of a key that already owns a voice shall not allocate a second voice.
REQ-018 A release shall free the voice owning that key on the next cycle and clear the key's pending bit; the freed voice's phase shall reset to 0.
REQ-019 A release shall take precedence over a pending press of the same key arriving in the same cycle.
REQ-020 Each voice shall hold an age counter; it is zeroed on allocation and saturates at its maximum value.
REQ-021 Key period table, key 0..12: 75,70,67,63,59,56,53,50,47,44,42,40,37.
REQ-022 Voice divider period shall be table[key] << oct_sel; oct_sel changes take effect at the next divider wrap.
REQ-023 At each divider wrap the voice phase shall increment by 1, mod 2^SAMPLE_W.
REQ-024 Shaping of phase p: saw = p; square = all-ones if MSB(p) = 1, else 0; triangle = (p << 1) if MSB(p) = 0, else ~(p << 1); silent = 0.
REQ-025 Every SAMPLE_DIV cycles the mixer shall compute (sum of shaped outputs of active voices) >> log2(NUM_VOICES) with a full-width accumulator, with no overflow; sample shall register the result and sample_valid shall pulse in the same cycle.
REQ-026 Inactive voices shall contribute 0 to the mix.

Reset
REQ-027 While reset is high: sample = 0, sample_valid = 0, voice_active = 0, alloc_drop = 0; all pending bits, phases, dividers, ages, key registers and the sample counter are 0.
REQ-028 Reset asserted mid-note shall free all voices immediately. After release, keys held through reset shall be treated as new presses.

Configuration
REQ-029 Macro VOICE_STEAL_EN defined: a press with no free voice shall steal the voice with the greatest age (lowest index on ties), reassign it to the new key, zero its phase and age, and not pulse alloc_drop.
REQ-030 Macro VOICE_STEAL_EN undefined: a press with no free voice shall be discarded, its pending bit cleared, and alloc_drop pulsed for 1 cycle.

Verification
REQ-031 Defaults; hold keys[0] = 1, oct_sel = 0, wave_sel = 0 -> voice_active = 4'b0001 at cycle +2; phase increments every 75 cycles; sample = phase >> 2 at each sample_valid.
REQ-032 Set keys 0,1,2 high in the same cycle -> voices 0,1,2 are allocated on consecutive cycles, ending with voice_active = 4'b0111; release key 1 -> voice_active = 4'b0101.
REQ-033 Hold keys 0..3, then press key 4 -> with VOICE_STEAL_EN: voice 0 is reassigned to key 4 and alloc_drop stays 0; without the macro: voice_active = 4'b1111 unchanged and alloc_drop pulses once.
REQ-034 keys[12] held with oct_sel = 3 -> divider period 296 cycles; wave_sel = 1 -> sample toggles between 0 and 63 (255 >> 2).
REQ-035 Assert reset while 3 voices are active -> all outputs are 0 asynchronously; deassert with keys held -> voices are reallocated starting 2 cycles later.
REQ-036 Press and release a key in the same cycle as a pending press of it -> no allocation and voice_active unchanged.
